// File: rtl/tspp_types_pkg.sv
// Shared types for the two-stage pipeline: machine word, fetch FSM states, fetch constants.
package tspp_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fe_ctrl_state_t;

    localparam word_t FE_PC_INC   = WORD_W'(4);
    localparam word_t FE_RESET_PC = 32'h0000_0200;

endpackage : tspp_types_pkg

// File: rtl/fe_pipe_latch.sv
// Fetch->execute latch: load a new instruction, hold it while execute stalls, otherwise drop it.
module fe_pipe_latch
    import tspp_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  flush,
    input  logic  hold,
    input  word_t pc_in,
    input  word_t instr_in,
    input  word_t npc_in,
    output logic  valid,
    output word_t pc,
    output word_t instr,
    output word_t npc
);

    logic  valid_d, valid_q;
    word_t pc_d, pc_q;
    word_t instr_d, instr_q;
    word_t npc_d, npc_q;

    // Load wins; a held entry survives unless flushed; anything else is consumed.
    always_comb begin
        valid_d = 1'b0;
        pc_d    = pc_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
            npc_d   = npc_in;
        end else if (hold && !flush) begin
            valid_d = valid_q;
        end
    end

    // Latch registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            npc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;
    assign npc   = npc_q;

endmodule : fe_pipe_latch

// File: rtl/fetch_execute_ctrl.sv
// Fetch sequencer: owns the PC, drives imem reads and feeds the fetch->execute latch,
// reacting to execute-side stall, redirect and halt.
module fetch_execute_ctrl
    import tspp_types_pkg::*;
#(
    parameter word_t RESET_PC = FE_RESET_PC,
    parameter word_t PC_INC   = FE_PC_INC
) (
    input  logic  CLK,
    input  logic  RST,
    output logic  imem_ren,
    output word_t imem_addr,
    input  logic  imem_busy,
    input  word_t imem_rdata,
    input  logic  ex_stall,
    input  logic  ex_redirect,
    input  word_t ex_target,
    input  logic  ex_halt,
    output logic  fe_valid,
    output word_t fe_pc,
    output word_t fe_instr,
    output word_t fe_npc,
    output logic  halted
);

    fe_ctrl_state_t state_d, state_q;
    word_t          pc_d, pc_q;
    word_t          drain_addr_d, drain_addr_q;
    logic           halt_pend_d, halt_pend_q;
    logic           halted_d, halted_q;

    logic  lat_load, lat_flush, lat_hold;
    logic  in_fetch, slot_free, halt_act, redir_act, capture;
    word_t pc_inc;

    assign in_fetch  = (state_q == FETCH);
    assign slot_free = !fe_valid || !ex_stall;
    assign halt_act  = in_fetch && fe_valid && !ex_stall && ex_halt;
    assign redir_act = in_fetch && fe_valid && ex_redirect && !halt_act;
    assign capture   = in_fetch && !imem_busy && slot_free && !ex_redirect && !ex_halt;
    assign pc_inc    = pc_q + PC_INC;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= START;
        else     state_q <= state_d;
    end

    // Next-state: a busy imem at redirect/halt forces a drain of the open request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            START:   state_d = FETCH;
            FETCH: begin
                if (halt_act)                    state_d = imem_busy ? DRAIN : HALTED;
                else if (redir_act && imem_busy) state_d = DRAIN;
            end
            DRAIN:   if (!imem_busy) state_d = halt_pend_q ? HALTED : FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = START;
        endcase
    end

    // Imem request decode; the drained address stays on the bus until the response lands.
    always_comb begin
        imem_ren  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            FETCH:   imem_ren = 1'b1;
            DRAIN: begin
                imem_ren  = 1'b1;
                imem_addr = drain_addr_q;
            end
            default: imem_ren = 1'b0;
        endcase
    end

    // PC, drain bookkeeping and latch control; halt beats redirect beats capture.
    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        halt_pend_d  = halt_pend_q;
        lat_load     = 1'b0;
        lat_flush    = 1'b0;
        lat_hold     = 1'b1;
        case (state_q)
            FETCH: begin
                lat_hold = ex_stall;
                if (halt_act) begin
                    lat_flush = 1'b1;
                    if (imem_busy) begin
                        halt_pend_d  = 1'b1;
                        drain_addr_d = pc_q;
                    end
                end else if (redir_act) begin
                    lat_flush = 1'b1;
                    pc_d      = ex_target;
                    if (imem_busy) drain_addr_d = pc_q;
                end else if (capture) begin
                    lat_load = 1'b1;
                    pc_d     = pc_inc;
                end
            end
            DRAIN: begin
                lat_flush = 1'b1;
                if (ex_redirect) pc_d = ex_target;
            end
            HALTED:  lat_flush = 1'b1;
            default: lat_hold  = 1'b1;
        endcase
        halted_d = (state_d == HALTED);
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            halt_pend_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            halt_pend_q  <= halt_pend_d;
            halted_q     <= halted_d;
        end
    end

    assign halted = halted_q;

    fe_pipe_latch u_latch (
        .CLK      (CLK),
        .RST      (RST),
        .load     (lat_load),
        .flush    (lat_flush),
        .hold     (lat_hold),
        .pc_in    (pc_q),
        .instr_in (imem_rdata),
        .npc_in   (pc_inc),
        .valid    (fe_valid),
        .pc       (fe_pc),
        .instr    (fe_instr),
        .npc      (fe_npc)
    );

endmodule : fetch_execute_ctrl
